// File: rtl/rv_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_decode_pkg
// Purpose  : Shared RV32 decode constants: major opcodes, one-hot class bit
//            indices, exact system words and the immediate format selector.
// Revision : 1.0  initial release
// ============================================================================
package rv_decode_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  // One-hot class vector layout {mach, csr, cust, mem, jmp, alu}
  localparam int CLS_W    = 6;
  localparam int CLS_ALU  = 0;
  localparam int CLS_JMP  = 1;
  localparam int CLS_MEM  = 2;
  localparam int CLS_CUST = 3;
  localparam int CLS_CSR  = 4;
  localparam int CLS_MACH = 5;

  // Machine-level SYSTEM words recognised only as exact encodings
  localparam logic [31:0] WORD_ECALL  = 32'h0000_0073;
  localparam logic [31:0] WORD_EBREAK = 32'h0010_0073;
  localparam logic [31:0] WORD_MRET   = 32'h3020_0073;
  localparam logic [31:0] WORD_WFI    = 32'h1050_0073;

  // Immediate extraction format
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_CSR  = 3'd6
  } imm_fmt_e;

endpackage
`default_nettype wire

// File: rtl/rv_decode_comb.sv
`default_nettype none
// ============================================================================
// Module   : rv_decode_comb
// Purpose  : Purely combinational RV32 word decoder.
// Ports    : instr   in  32      instruction word
//            cls     out 6       one-hot class {mach,csr,cust,mem,jmp,alu}
//            illegal out 1       no class matched
//            rd_we   out 1       writes rd (never for rd==0)
//            imm     out XLEN    sign-extended immediate (0 where none)
// Revision : 1.0  initial release
// ============================================================================
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter logic [6:0] CUST_OPCODE = 7'h7F
) (
  input  logic [31:0]      instr,
  output logic [CLS_W-1:0] cls,
  output logic             illegal,
  output logic             rd_we,
  output logic [XLEN-1:0]  imm
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        writes;
  imm_fmt_e    fmt;
  logic [31:0] imm32;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];

  always_comb begin
    cls    = '0;
    fmt    = FMT_NONE;
    writes = 1'b0;
    // Non-32-bit encodings (low bits != 11) never match any class.
    if (instr[1:0] == 2'b11) begin
      if (opc == CUST_OPCODE) begin
        cls[CLS_CUST] = 1'b1;
        writes        = 1'b1;
      end else begin
        case (opc)
          OPC_LUI, OPC_AUIPC: begin
            cls[CLS_ALU] = 1'b1; fmt = FMT_U; writes = 1'b1;
          end
          OPC_OP_IMM: begin
            cls[CLS_ALU] = 1'b1; fmt = FMT_I; writes = 1'b1;
          end
          OPC_OP: begin
            cls[CLS_ALU] = 1'b1; writes = 1'b1;
          end
          OPC_JAL: begin
            cls[CLS_JMP] = 1'b1; fmt = FMT_J; writes = 1'b1;
          end
          OPC_JALR: begin
            if (f3 == 3'd0) begin
              cls[CLS_JMP] = 1'b1; fmt = FMT_I; writes = 1'b1;
            end
          end
          OPC_BRANCH: begin
            if (f3 != 3'd2 && f3 != 3'd3) begin
              cls[CLS_JMP] = 1'b1; fmt = FMT_B;
            end
          end
          OPC_LOAD: begin
            if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) begin
              cls[CLS_MEM] = 1'b1; fmt = FMT_I; writes = 1'b1;
            end
          end
          OPC_STORE: begin
            if (f3 <= 3'd2) begin
              cls[CLS_MEM] = 1'b1; fmt = FMT_S;
            end
          end
          OPC_MISC_MEM: begin
            // Only FENCE (funct3=0) is accepted; treated as a machine op.
            if (f3 == 3'd0) cls[CLS_MACH] = 1'b1;
          end
          OPC_SYSTEM: begin
            if (f3 != 3'd0 && f3 != 3'd4) begin
              cls[CLS_CSR] = 1'b1; fmt = FMT_CSR; writes = 1'b1;
            end else if (instr == WORD_ECALL || instr == WORD_EBREAK ||
                         instr == WORD_MRET  || instr == WORD_WFI) begin
              cls[CLS_MACH] = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      // CSR address is zero-extended; bit 31 is 0 so the sign extension below keeps it positive.
      FMT_CSR: imm32 = {20'b0, instr[31:20]};
      default: imm32 = 32'b0;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_imm_wide
      assign imm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_imm_native
      assign imm = imm32[XLEN-1:0];
    end
  endgenerate

  assign illegal = ~|cls;
  assign rd_we   = writes && (instr[11:7] != 5'd0);

endmodule
`default_nettype wire

// File: rtl/instr_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_decode_queue
// Purpose  : Buffered RV32 decode stage: DEPTH-entry fetch queue, combinational
//            decode of the head entry, registered output bundle.
// Ports    : clk, rst_n (async active-low), flush
//            in_valid/in_ready/in_instr/in_pc        fetch side handshake
//            dec_valid/dec_ready and dec_* bundle    issue side handshake
//            occupancy                                valid queue entries
// Revision : 1.0  initial release
// ============================================================================
module instr_decode_queue
  import rv_decode_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         DEPTH       = 4,
  parameter logic [6:0] CUST_OPCODE = 7'h7F
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [XLEN-1:0]            dec_pc,
  output logic [5:0]                 dec_class,
  output logic                       dec_illegal,
  output logic [4:0]                 dec_rd,
  output logic [4:0]                 dec_rs1,
  output logic [4:0]                 dec_rs2,
  output logic                       dec_rd_we,
  output logic [XLEN-1:0]            dec_imm,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                OCC_W    = $clog2(DEPTH+1);
  localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(DEPTH);

  logic [31:0]       q_instr [DEPTH];
  logic [XLEN-1:0]   q_pc    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              push;
  logic              pop;
  logic [31:0]       head_instr;
  logic [CLS_W-1:0]  head_cls;
  logic              head_illegal;
  logic              head_rd_we;
  logic [XLEN-1:0]   head_imm;

  // Ready depends only on registered occupancy and flush, so a full queue
  // does not open up in the same cycle it is popped.
  assign in_ready = !flush && (occupancy < OCC_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = !flush && (occupancy != '0) && (!dec_valid || dec_ready);

  assign head_instr = q_instr[rd_ptr];

  rv_decode_comb #(
    .XLEN        (XLEN),
    .CUST_OPCODE (CUST_OPCODE)
  ) u_decode (
    .instr   (head_instr),
    .cls     (head_cls),
    .illegal (head_illegal),
    .rd_we   (head_rd_we),
    .imm     (head_imm)
  );

  // Storage carries no reset: entry validity lives entirely in occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= in_instr;
      q_pc[wr_ptr]    <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid   <= 1'b0;
      dec_pc      <= '0;
      dec_class   <= '0;
      dec_illegal <= 1'b0;
      dec_rd      <= '0;
      dec_rs1     <= '0;
      dec_rs2     <= '0;
      dec_rd_we   <= 1'b0;
      dec_imm     <= '0;
    end else if (flush) begin
      dec_valid <= 1'b0;
    end else if (pop) begin
      dec_valid   <= 1'b1;
      dec_pc      <= q_pc[rd_ptr];
      dec_class   <= head_cls;
      dec_illegal <= head_illegal;
      dec_rd      <= head_instr[11:7];
      dec_rs1     <= head_instr[19:15];
      dec_rs2     <= head_instr[24:20];
      dec_rd_we   <= head_rd_we;
      dec_imm     <= head_imm;
    end else if (dec_ready) begin
      dec_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
